// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit between core datapath and data memory
//
// Turns one core load/store request into a single data-memory transaction
// with byte enables and lane-replicated write data, formats returned load
// data (sign/zero extension) and stalls the core until the access retires.
//
// Optional feature macro: LSU_MISALIGN_EN
//   defined   : misaligned H/HU/W requests skip memory and pulse misaligned_o
//   undefined : misaligned_o tied to 0, misaligned accesses issued as-is
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), async active-low reset
//   core_req_i            core access request, held until stall drops
//   core_we_i             1 = store, 0 = load
//   core_size_i           funct3 size code (0=B 1=H 2=W 4=BU 5=HU)
//   core_addr_i           byte address
//   core_wd_i             store data
//   core_rd_o             formatted data of the last completed load
//   core_stall_o          core must hold PC and state
//   misaligned_o          misaligned-access exception pulse
//   mem_req_o             data-memory request
//   mem_we_o              data-memory write enable
//   mem_be_o              byte enables
//   mem_addr_o            full byte address (low bits kept)
//   mem_wd_o              lane-replicated write data
//   mem_rd_i              raw read word
//   mem_ready_i           memory completes the transaction this cycle
`timescale 1ns/1ps

module riscv_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              core_stall_o,
    output logic              misaligned_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,
    input  logic              mem_ready_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wd_q;
    logic [2:0]        size_q;
    logic              we_q;

    logic              in_access;
    logic              misalign;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wd;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_fmt;

    assign in_access = (state_q == S_ACCESS);

`ifdef LSU_MISALIGN_EN
    // Size codes 1 and 5 share low bits 01 (H/HU).
    assign misalign = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                      ((core_size_i == 3'd2) && (core_addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Store lane formatting from the captured request.
    always_comb begin
        st_be = 4'b0000;
        st_wd = wd_q;
        case (size_q)
            3'd0: begin
                st_be = 4'b0001 << addr_q[1:0];
                st_wd = {4{wd_q[7:0]}};
            end
            3'd1: begin
                st_be = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wd = {2{wd_q[15:0]}};
            end
            3'd2:    st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    // Load formatting of the raw word for the captured address/size.
    assign ld_byte = mem_rd_i[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    always_comb begin
        ld_fmt = '0;
        case (size_q)
            3'd0:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'd2:    ld_fmt = mem_rd_i;
            3'd4:    ld_fmt = {24'd0, ld_byte};
            3'd5:    ld_fmt = {16'd0, ld_half};
            default: ld_fmt = '0;
        endcase
    end

    // Memory outputs decode only registered state, so they are stable for
    // the whole ACCESS and drop the instant reset forces the FSM to IDLE.
    assign mem_req_o  = in_access;
    assign mem_we_o   = in_access & we_q;
    assign mem_be_o   = in_access ? (we_q ? st_be : 4'b1111) : 4'b0000;
    assign mem_addr_o = in_access ? addr_q : '0;
    assign mem_wd_o   = in_access ? st_wd : '0;

    assign core_stall_o = rst_ni & core_req_i & (state_q != S_RESP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wd_q      <= '0;
            size_q    <= 3'd0;
            we_q      <= 1'b0;
            core_rd_o <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (core_req_i) begin
                        addr_q  <= core_addr_i;
                        wd_q    <= core_wd_i;
                        size_q  <= core_size_i;
                        we_q    <= core_we_i;
                        state_q <= misalign ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ready_i) begin
                        if (!we_q) begin
                            core_rd_o <= ld_fmt;
                        end
                        state_q <= S_RESP;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef LSU_MISALIGN_EN
    logic mis_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= (state_q == S_IDLE) && core_req_i && misalign;
        end
    end

    assign misaligned_o = mis_q;
`else
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed self-checking bench for riscv_lsu
`timescale 1ns/1ps

module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misaligned_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    riscv_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .misaligned_o (misaligned_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full access: IDLE request cycle, wait_n+1 ACCESS cycles, one RESP
    // cycle. Inputs change on negedges, outputs are sampled on negedges.
    task automatic do_access(input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int wait_n,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd,
                             input bit drop_req);
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'b0;
        mem_rd_i    = 32'h0;
        #1;
        chk("idle_stall", core_stall_o, 1'b1);
        chk("idle_req", mem_req_o, 1'b0);
        @(negedge clk_i);
        for (int i = 0; i <= wait_n; i++) begin
            chk("acc_req", mem_req_o, 1'b1);
            chk("acc_we", mem_we_o, we);
            chk("acc_be", mem_be_o, exp_be);
            chk("acc_addr", mem_addr_o, addr);
            if (we) chk("acc_wd", mem_wd_o, exp_wd);
            chk("acc_stall", core_stall_o, core_req_i);
            if (drop_req && i == 0) core_req_i = 1'b0;
            if (i == wait_n) begin
                mem_ready_i = 1'b1;
                mem_rd_i    = rd;
            end
            @(negedge clk_i);
        end
        chk("resp_req", mem_req_o, 1'b0);
        chk("resp_stall", core_stall_o, 1'b0);
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("back_idle_req", mem_req_o, 1'b0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_rd", core_rd_o, 32'h0);
        chk("rst_stall", core_stall_o, 1'b0);
        chk("rst_mis", misaligned_o, 1'b0);
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_we", mem_we_o, 1'b0);
        chk("rst_be", mem_be_o, 4'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_wd", mem_wd_o, 32'h0);
        rst_ni = 1'b1;

        // ready outside ACCESS is ignored
        @(negedge clk_i);
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        chk("ready_idle_req", mem_req_o, 1'b0);
        chk("ready_idle_rd", core_rd_o, 32'h0);
        mem_ready_i = 1'b0;

        // stores
        do_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 0);
        do_access(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 4'b1000, 32'hA5A5A5A5, 0);
        do_access(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 0, 4'b1100, 32'hABCDABCD, 0);
        do_access(1'b1, 3'd0, 32'h101, 32'h00000077, 32'h0, 0, 4'b0010, 32'h77777777, 0);
        do_access(1'b1, 3'd3, 32'h104, 32'h11223344, 32'h0, 0, 4'b0000, 32'h11223344, 0);
        chk("store_keeps_rd", core_rd_o, 32'h0);

        // loads
        do_access(1'b0, 3'd0, 32'h102, 32'h0, 32'h1280FF34, 0, 4'b1111, 32'h0, 0);
        chk("lb", core_rd_o, 32'hFFFFFF80);
        do_access(1'b0, 3'd4, 32'h102, 32'h0, 32'h1280FF34, 0, 4'b1111, 32'h0, 0);
        chk("lbu", core_rd_o, 32'h00000080);
        do_access(1'b0, 3'd1, 32'h102, 32'h0, 32'h1280FF34, 0, 4'b1111, 32'h0, 0);
        chk("lh_hi", core_rd_o, 32'h00001280);
        do_access(1'b0, 3'd1, 32'h100, 32'h0, 32'h1280FF34, 0, 4'b1111, 32'h0, 0);
        chk("lh_lo", core_rd_o, 32'hFFFFFF34);
        do_access(1'b0, 3'd5, 32'h100, 32'h0, 32'h1280FF34, 0, 4'b1111, 32'h0, 0);
        chk("lhu", core_rd_o, 32'h0000FF34);
        do_access(1'b0, 3'd0, 32'h101, 32'h0, 32'h1280FF34, 0, 4'b1111, 32'h0, 0);
        chk("lb_b1", core_rd_o, 32'hFFFFFFFF);
        do_access(1'b0, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 5, 4'b1111, 32'h0, 0);
        chk("lw_wait", core_rd_o, 32'hCAFEF00D);
        do_access(1'b0, 3'd7, 32'h200, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'h0, 0);
        chk("l_bad_size", core_rd_o, 32'h0);

        // request dropped mid-ACCESS still completes
        do_access(1'b0, 3'd2, 32'h300, 32'h0, 32'h5A5A1234, 1, 4'b1111, 32'h0, 1);
        chk("drop_req_rd", core_rd_o, 32'h5A5A1234);

        // async reset mid-ACCESS
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = 1'b1;
        core_size_i = 3'd2;
        core_addr_i = 32'h400;
        core_wd_i   = 32'h0BADF00D;
        @(negedge clk_i);
        chk("pre_rst_req", mem_req_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_mid_req", mem_req_o, 1'b0);
        chk("rst_mid_stall", core_stall_o, 1'b0);
        chk("rst_mid_rd", core_rd_o, 32'h0);
        core_req_i = 1'b0;
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_req", mem_req_o, 1'b0);
        do_access(1'b0, 3'd2, 32'h404, 32'h0, 32'h87654321, 0, 4'b1111, 32'h0, 0);
        chk("post_rst_lw", core_rd_o, 32'h87654321);

`ifdef LSU_MISALIGN_EN
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h102;
        @(negedge clk_i);
        chk("mis_req", mem_req_o, 1'b0);
        chk("mis_pulse", misaligned_o, 1'b1);
        chk("mis_stall", core_stall_o, 1'b0);
        chk("mis_rd", core_rd_o, 32'h87654321);
        core_req_i = 1'b0;
        @(negedge clk_i);
        chk("mis_pulse_end", misaligned_o, 1'b0);
        chk("mis_idle_req", mem_req_o, 1'b0);
`else
        do_access(1'b0, 3'd2, 32'h102, 32'h0, 32'h13572468, 0, 4'b1111, 32'h0, 0);
        chk("mis_lw_rd", core_rd_o, 32'h13572468);
        chk("mis_tied", misaligned_o, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit. It is the responder for the decoder's memory controls (mem_req, mem_we, mem_size), and it sits between the core datapath and the data memory. It turns a core load/store request into one data-memory transaction with byte enables and lane replication, sign- or zero-extends load data, and stalls the core until the transaction completes.

Parameters:
ADDR_W, 32, width of byte address.
DATA_W, 32, data width. Only 32 is supported.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  reset, asynchronous, active-low.
core_req_i  in  1  core requests a memory access; held high until stall drops.
core_we_i  in  1  1 = store, 0 = load.
core_size_i  in  3  funct3 size code: 0=B, 1=H, 2=W, 4=BU, 5=HU.
core_addr_i  in  ADDR_W  byte address (ALU result).
core_wd_i  in  DATA_W  store data (rs2).
core_rd_o  out  DATA_W  formatted load data.
core_stall_o  out  1  core must hold the PC and all state.
misaligned_o  out  1  misaligned-access exception pulse (see Optional Feature).
mem_req_o  out  1  data-memory request.
mem_we_o  out  1  data-memory write enable.
mem_be_o  out  4  byte enables.
mem_addr_o  out  ADDR_W  data-memory address.
mem_wd_o  out  DATA_W  lane-replicated write data.
mem_rd_i  in  DATA_W  raw read word.
mem_ready_i  in  1  memory completes the transaction this cycle.

Behaviour:
Reset values:
- All outputs are 0.
- FSM is in IDLE.
- Captured address, data, size and we registers are 0.

FSM states: IDLE, ACCESS, RESP.
- IDLE, core_req_i=1: capture addr/wd/size/we; go to ACCESS.
- IDLE, core_req_i=0: stay in IDLE.
- ACCESS: mem_req_o=1, and mem_we_o/mem_be_o/mem_addr_o/mem_wd_o come from the captured registers. All memory outputs are registered and stable for the whole ACCESS.
- ACCESS, mem_ready_i=1: for a load, register the formatted mem_rd_i into core_rd_o. Go to RESP.
- ACCESS, mem_ready_i=0: stay in ACCESS; there is no timeout.
- RESP: mem_req_o=0; go to IDLE unconditionally.

core_stall_o (combinational): core_req_i & (state != RESP).
- Core sees exactly one unstalled cycle per access, in RESP.
- Minimum latency: request in cycle 0 (IDLE), ready in cycle 1 (ACCESS), unstall in cycle 2.

core_rd_o:
- Holds the last completed load value.
- Stores and misaligned accesses do not change it.

mem_addr_o: the full captured address; the low bits are not cleared.

Store formatting (lane = addr[1:0]):
- B: be = 4'b0001 << lane; wd = {4{wd[7:0]}}.
- H: be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{wd[15:0]}}.
- W: be = 4'b1111; wd unchanged.
- Size 3, 6, 7 (store): be = 4'b0000; a transaction is still issued.

Load formatting:
- B/BU: select byte addr[1:0]; sign- / zero-extend.
- H/HU: select half addr[1]; sign- / zero-extend.
- W: whole word.
- Size 3, 6, 7 (load): result is 0.
- Load transactions drive be = 4'b1111.

Boundary conditions:
- core_req_i deasserted during ACCESS: the transaction still completes through RESP; it cannot be aborted.
- core_req_i high in RESP: this is the same request retiring; no new capture. A new request is captured only in IDLE, so back-to-back accesses are separated by the IDLE cycle.
- rst_ni low mid-ACCESS: mem_req_o drops immediately (asynchronously) and the FSM goes to IDLE; the memory tolerates the abandoned request.
- mem_ready_i outside ACCESS: ignored.

Optional Feature:
Macro: LSU_MISALIGN_EN.
- Defined: in IDLE, a request with H/HU and addr[0]=1, or W with addr[1:0]!=0, is misaligned.
  - No memory transaction is issued; the FSM goes straight to RESP.
  - misaligned_o=1 for that RESP cycle only; core_rd_o unchanged.
  - Stall drops in the RESP cycle as usual.
- Undefined: misaligned_o is tied to 0. Misaligned accesses are issued using the lane rules above; W ignores addr[1:0] for lane selection.

Test Plan:
- SW addr=0x100, wd=0xDEADBEEF, ready asserted 1 cycle after entering ACCESS -> exactly one ACCESS cycle with mem_req_o=1, we=1, be=1111, wd=0xDEADBEEF, addr=0x100; stall high 2 cycles, low in cycle 2.
- SB addr=0x103, wd=0x000000A5 -> be=1000, mem_wd_o=0xA5A5A5A5.
- LB addr=0x102, mem_rd_i=0x1280FF34 -> core_rd_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LH addr=0x102 -> 0x00001280.
- LW with mem_ready_i held low 5 cycles -> mem_req_o and outputs stable for 6 ACCESS cycles; stall high throughout; single RESP cycle; core_rd_o equals mem_rd_i.
- rst_ni pulsed low during ACCESS -> mem_req_o=0 and core_stall_o=0 in the same cycle; FSM in IDLE; the next request completes normally.
- With LSU_MISALIGN_EN: LW addr=0x102 -> no mem_req_o; misaligned_o=1 for one cycle; core_rd_o unchanged. Without the macro: the same access issues be=1111, addr=0x102.
